// File: rtl/nav_spi_responder_if.sv
// SPI pad bundle between a PMOD NAV style initiator and the in-fabric responder.
interface nav_spi_responder_if;
    logic cs_n;
    logic spc;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (
        output cs_n,
        output spc,
        output mosi,
        input  miso,
        input  miso_oe
    );

    modport slave (
        input  cs_n,
        input  spc,
        input  mosi,
        output miso,
        output miso_oe
    );
endinterface

// File: rtl/nav_spi_responder.sv
// LSM9DS1-style SPI responder (mode 3) backed by a 128 x 8 register file.
// Command byte = {rw, addr[6:0]}, then auto-incrementing data bytes.
module nav_spi_responder #(
    parameter logic [7:0]  WHO_AM_I_VAL = 8'h68,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    nav_spi_responder_if.slave        spi,
    input  logic                      ld_en,
    input  logic [6:0]                ld_addr,
    input  logic [7:0]                ld_data,
    input  logic [6:0]                rd_addr,
    output logic [7:0]                rd_data,
    output logic                      spi_wr_valid,
    output logic [6:0]                spi_wr_addr,
    output logic [7:0]                spi_wr_data
);

    localparam logic [6:0] WhoAmIAddr = 7'h0F;

    typedef enum logic [1:0] {StIdle, StCmd, StData} state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] spc_sync_q, spc_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic cs_s, spc_s, mosi_s;
    logic cs_prev_q, spc_prev_q;
    logic cs_fall, cs_rise, spc_rise, spc_fall;

    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] rx_q, rx_d;
    logic [7:0] rx_byte;
    logic [7:0] tx_q, tx_d;
    logic       miso_bit_q, miso_bit_d;
    logic       rw_q, rw_d;
    logic [6:0] addr_q, addr_d;
    logic       spi_we;
    logic       oe;

    logic [6:0] load_addr;
    logic [7:0] load_val;

    logic [7:0] regs_q [128];
    logic [7:0] regs_d [128];

    logic [7:0] rd_data_q, rd_data_d;
    logic       wr_valid_q, wr_valid_d;
    logic [6:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;

    assign cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi.cs_n};
    assign spc_sync_d  = {spc_sync_q[SYNC_STAGES-2:0], spi.spc};
    assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};

    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign spc_s  = spc_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign cs_fall  = ~cs_s & cs_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;
    assign spc_rise = spc_s & ~spc_prev_q;
    assign spc_fall = ~spc_s & spc_prev_q;

    assign rx_byte = {rx_q, mosi_s};

    // At the end of the command byte the address comes straight from the shifter.
    assign load_addr = (state_q == StCmd) ? rx_byte[6:0] : addr_q;
    assign load_val  = (load_addr == WhoAmIAddr) ? WHO_AM_I_VAL : regs_q[load_addr];

    assign oe          = (state_q == StData) && rw_q && !cs_s;
    assign spi.miso_oe = oe;
    assign spi.miso    = oe & miso_bit_q;

    assign rd_data      = rd_data_q;
    assign spi_wr_valid = wr_valid_q;
    assign spi_wr_addr  = wr_addr_q;
    assign spi_wr_data  = wr_data_q;

    // Synchronizers and edge-detect history. cs_n resets asserted so a cs_n held low
    // across reset release is not mistaken for a new falling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_sync_q   <= '0;
            spc_sync_q  <= '1;
            mosi_sync_q <= '0;
            cs_prev_q   <= 1'b0;
            spc_prev_q  <= 1'b1;
        end else begin
            cs_sync_q   <= cs_sync_d;
            spc_sync_q  <= spc_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_prev_q   <= cs_s;
            spc_prev_q  <= spc_s;
        end
    end

    // Protocol state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            rx_q       <= '0;
            tx_q       <= '0;
            miso_bit_q <= 1'b0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            miso_bit_q <= miso_bit_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
        end
    end

    // Next-state: command decode, byte framing, read preload and write commit.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        miso_bit_d = miso_bit_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        spi_we     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    state_d   = StCmd;
                    bit_cnt_d = '0;
                end
            end
            StCmd: begin
                if (spc_rise) begin
                    rx_d      = rx_byte[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StData;
                        rw_d    = rx_byte[7];
                        if (rx_byte[7]) begin
                            tx_d   = load_val;
                            addr_d = rx_byte[6:0] + 7'd1;
                        end else begin
                            addr_d = rx_byte[6:0];
                        end
                    end
                end
            end
            StData: begin
                if (spc_rise) begin
                    rx_d      = rx_byte[6:0];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        addr_d = addr_q + 7'd1;
                        if (rw_q) begin
                            tx_d = load_val;
                        end else begin
                            spi_we = 1'b1;
                        end
                    end
                end
                // Loaded byte stays in tx_q until the next falling edge presents its MSB.
                if (spc_fall) begin
                    miso_bit_d = tx_q[7];
                    tx_d       = {tx_q[6:0], 1'b0};
                end
            end
            default: state_d = StIdle;
        endcase

        // Deselect always wins; any partial byte is dropped.
        if (cs_rise) begin
            state_d   = StIdle;
            bit_cnt_d = '0;
        end
    end

    // Register file next-state: SPI write applied last so it wins a same-address collision.
    always_comb begin
        regs_d = regs_q;
        if (ld_en && (ld_addr != WhoAmIAddr)) begin
            regs_d[ld_addr] = ld_data;
        end
        if (spi_we && (addr_q != WhoAmIAddr)) begin
            regs_d[addr_q] = rx_byte;
        end
    end

    // Register file storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 128; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Local read port and SPI write notification next-state.
    always_comb begin
        rd_data_d  = (rd_addr == WhoAmIAddr) ? WHO_AM_I_VAL : regs_q[rd_addr];
        wr_valid_d = spi_we;
        wr_addr_d  = spi_we ? addr_q : wr_addr_q;
        wr_data_d  = spi_we ? rx_byte : wr_data_q;
    end

    // Registered local-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q  <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            rd_data_q  <= rd_data_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_nav_spi_responder.sv
// Directed bench for nav_spi_responder: local-port vector table plus SPI sequences.
module tb_nav_spi_responder;

    localparam int Half = 6;  // clk periods per spc phase

    logic       clk = 1'b0;
    logic       rst;
    logic       ld_en;
    logic [6:0] ld_addr;
    logic [7:0] ld_data;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;
    logic       spi_wr_valid;
    logic [6:0] spi_wr_addr;
    logic [7:0] spi_wr_data;

    nav_spi_responder_if spi_bus ();

    nav_spi_responder #(
        .WHO_AM_I_VAL (8'h68),
        .SYNC_STAGES  (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .spi          (spi_bus),
        .ld_en        (ld_en),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .spi_wr_valid (spi_wr_valid),
        .spi_wr_addr  (spi_wr_addr),
        .spi_wr_data  (spi_wr_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] tx_buf [8];
    logic [7:0] rx_buf [8];
    bit         oe_any [8];
    bit         oe_all [8];

    logic [6:0] wq_addr [$];
    logic [7:0] wq_data [$];

    typedef struct {
        logic       en;
        logic [6:0] la;
        logic [7:0] ld;
        logic [6:0] ra;
        logic [7:0] exp;
    } lvec_t;

    lvec_t lv [9];

    // Record every SPI write commit.
    always @(negedge clk) begin
        if (spi_wr_valid === 1'b1) begin
            wq_addr.push_back(spi_wr_addr);
            wq_data.push_back(spi_wr_data);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One SPI byte (or nbits of it); optional ld_en pulse in the cycle the last bit commits.
    task automatic spi_byte(input int idx, input logic [7:0] b, input int nbits,
                            input bit do_ld, input logic [6:0] la, input logic [7:0] lval);
        logic [7:0] r;
        bit any;
        bit all;
        r   = '0;
        any = 1'b0;
        all = 1'b1;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_bus.spc  = 1'b0;
            spi_bus.mosi = b[i];
            repeat (Half) @(negedge clk);
            r[i] = spi_bus.miso;
            any  = any | spi_bus.miso_oe;
            all  = all & spi_bus.miso_oe;
            spi_bus.spc = 1'b1;
            for (int k = 0; k < Half; k++) begin
                @(negedge clk);
                if (do_ld && i == 0 && k == 1) begin
                    ld_en   = 1'b1;
                    ld_addr = la;
                    ld_data = lval;
                end
                if (do_ld && i == 0 && k == 2) begin
                    ld_en = 1'b0;
                    check("collision_wr_valid", {31'd0, spi_wr_valid}, 32'd1);
                end
            end
        end
        rx_buf[idx] = r;
        oe_any[idx] = any;
        oe_all[idx] = all;
    endtask

    task automatic spi_xfer(input int n);
        spi_bus.cs_n = 1'b0;
        repeat (Half) @(negedge clk);
        for (int j = 0; j < n; j++) begin
            spi_byte(j, tx_buf[j], 8, 1'b0, 7'h00, 8'h00);
        end
        repeat (Half) @(negedge clk);
        spi_bus.cs_n = 1'b1;
        repeat (Half) @(negedge clk);
    endtask

    task automatic set_tx(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
        tx_buf[0] = a;
        tx_buf[1] = b;
        tx_buf[2] = c;
        tx_buf[3] = d;
    endtask

    task automatic local_rd(input logic [6:0] a, output logic [7:0] v);
        rd_addr = a;
        @(negedge clk);
        v = rd_data;
    endtask

    task automatic clear_wq();
        wq_addr.delete();
        wq_data.delete();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] v;

        lv[0] = '{1'b1, 7'h05, 8'h3C, 7'h05, 8'h3C};
        lv[1] = '{1'b0, 7'h00, 8'h00, 7'h0F, 8'h68};
        lv[2] = '{1'b1, 7'h0F, 8'hFF, 7'h0F, 8'h68};
        lv[3] = '{1'b1, 7'h7F, 8'h55, 7'h7F, 8'h55};
        lv[4] = '{1'b1, 7'h00, 8'hAA, 7'h00, 8'hAA};
        lv[5] = '{1'b1, 7'h10, 8'h5A, 7'h10, 8'h5A};
        lv[6] = '{1'b0, 7'h00, 8'h00, 7'h06, 8'h00};
        lv[7] = '{1'b1, 7'h05, 8'h77, 7'h05, 8'h77};
        lv[8] = '{1'b0, 7'h00, 8'h00, 7'h7F, 8'h55};

        rst          = 1'b0;
        spi_bus.cs_n = 1'b1;
        spi_bus.spc  = 1'b1;
        spi_bus.mosi = 1'b0;
        ld_en        = 1'b0;
        ld_addr      = '0;
        ld_data      = '0;
        rd_addr      = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_miso", {31'd0, spi_bus.miso}, 32'd0);
        check("rst_miso_oe", {31'd0, spi_bus.miso_oe}, 32'd0);
        check("rst_rd_data", {24'd0, rd_data}, 32'd0);
        check("rst_wr_valid", {31'd0, spi_wr_valid}, 32'd0);
        check("rst_wr_addr", {25'd0, spi_wr_addr}, 32'd0);
        check("rst_wr_data", {24'd0, spi_wr_data}, 32'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Local write/read vector table
        for (int i = 0; i < 9; i++) begin
            ld_en   = lv[i].en;
            ld_addr = lv[i].la;
            ld_data = lv[i].ld;
            rd_addr = lv[i].ra;
            @(negedge clk);
            ld_en = 1'b0;
            @(negedge clk);
            check($sformatf("local_vec%0d", i), {24'd0, rd_data}, {24'd0, lv[i].exp});
        end

        // rd_data latency: same-edge write is seen one cycle later
        ld_en = 1'b1; ld_addr = 7'h40; ld_data = 8'h99; rd_addr = 7'h40;
        @(negedge clk);
        ld_en = 1'b0;
        check("rd_latency_old", {24'd0, rd_data}, 32'h00);
        @(negedge clk);
        check("rd_latency_new", {24'd0, rd_data}, 32'h99);

        // WHO_AM_I over SPI
        set_tx(8'h8F, 8'h00, 8'h00, 8'h00);
        spi_xfer(2);
        check("who_byte2", {24'd0, rx_buf[1]}, 32'h68);
        check("who_byte1_miso", {24'd0, rx_buf[0]}, 32'h00);
        check("who_oe_byte1_low", {31'd0, oe_any[0]}, 32'd0);
        check("who_oe_byte2_high", {31'd0, oe_all[1]}, 32'd1);

        // Burst write then burst read
        clear_wq();
        set_tx(8'h20, 8'hA1, 8'hB2, 8'hC3);
        spi_xfer(4);
        check("burst_wr_count", wq_addr.size(), 32'd3);
        if (wq_addr.size() == 3) begin
            check("burst_wr_a0", {25'd0, wq_addr[0]}, 32'h20);
            check("burst_wr_d0", {24'd0, wq_data[0]}, 32'hA1);
            check("burst_wr_a1", {25'd0, wq_addr[1]}, 32'h21);
            check("burst_wr_d1", {24'd0, wq_data[1]}, 32'hB2);
            check("burst_wr_a2", {25'd0, wq_addr[2]}, 32'h22);
            check("burst_wr_d2", {24'd0, wq_data[2]}, 32'hC3);
        end
        set_tx(8'hA0, 8'h00, 8'h00, 8'h00);
        spi_xfer(4);
        check("burst_rd_0", {24'd0, rx_buf[1]}, 32'hA1);
        check("burst_rd_1", {24'd0, rx_buf[2]}, 32'hB2);
        check("burst_rd_2", {24'd0, rx_buf[3]}, 32'hC3);

        // Address wrap 0x7F -> 0x00
        set_tx(8'hFF, 8'h00, 8'h00, 8'h00);
        spi_xfer(3);
        check("wrap_7f", {24'd0, rx_buf[1]}, 32'h55);
        check("wrap_00", {24'd0, rx_buf[2]}, 32'hAA);

        // Abort a write data byte after 5 bits
        clear_wq();
        spi_bus.cs_n = 1'b0;
        repeat (Half) @(negedge clk);
        spi_byte(0, 8'h10, 8, 1'b0, 7'h00, 8'h00);
        spi_byte(1, 8'hFF, 5, 1'b0, 7'h00, 8'h00);
        repeat (Half) @(negedge clk);
        spi_bus.cs_n = 1'b1;
        repeat (Half) @(negedge clk);
        check("abort_no_wr", wq_addr.size(), 32'd0);
        local_rd(7'h10, v);
        check("abort_reg_kept", {24'd0, v}, 32'h5A);
        set_tx(8'h90, 8'h00, 8'h00, 8'h00);
        spi_xfer(2);
        check("abort_next_txn", {24'd0, rx_buf[1]}, 32'h5A);

        // Write collisions: same address (SPI wins), different address (both land)
        spi_bus.cs_n = 1'b0;
        repeat (Half) @(negedge clk);
        spi_byte(0, 8'h30, 8, 1'b0, 7'h00, 8'h00);
        spi_byte(1, 8'h11, 8, 1'b1, 7'h30, 8'h22);
        spi_byte(2, 8'h44, 8, 1'b1, 7'h32, 8'h55);
        repeat (Half) @(negedge clk);
        spi_bus.cs_n = 1'b1;
        repeat (Half) @(negedge clk);
        local_rd(7'h30, v);
        check("collide_same", {24'd0, v}, 32'h11);
        local_rd(7'h31, v);
        check("collide_diff_spi", {24'd0, v}, 32'h44);
        local_rd(7'h32, v);
        check("collide_diff_ld", {24'd0, v}, 32'h55);

        // SPI write to WHO_AM_I: pulse still seen, contents unchanged
        clear_wq();
        set_tx(8'h0F, 8'h99, 8'h00, 8'h00);
        spi_xfer(2);
        check("who_wr_pulse", wq_addr.size(), 32'd1);
        if (wq_addr.size() == 1) begin
            check("who_wr_addr", {25'd0, wq_addr[0]}, 32'h0F);
            check("who_wr_data", {24'd0, wq_data[0]}, 32'h99);
        end
        local_rd(7'h0F, v);
        check("who_local_after_wr", {24'd0, v}, 32'h68);
        set_tx(8'h8F, 8'h00, 8'h00, 8'h00);
        spi_xfer(2);
        check("who_spi_after_wr", {24'd0, rx_buf[1]}, 32'h68);

        // Reset during a read data byte (0x68: bit 3 is a 1)
        clear_wq();
        spi_bus.cs_n = 1'b0;
        repeat (Half) @(negedge clk);
        spi_byte(0, 8'h8F, 8, 1'b0, 7'h00, 8'h00);
        spi_byte(1, 8'h00, 4, 1'b0, 7'h00, 8'h00);
        check("midrst_pre_oe", {31'd0, oe_all[1]}, 32'd1);
        spi_bus.spc = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_pre_miso", {31'd0, spi_bus.miso}, 32'd1);
        rst = 1'b0;
        #1;
        check("midrst_oe", {31'd0, spi_bus.miso_oe}, 32'd0);
        check("midrst_miso", {31'd0, spi_bus.miso}, 32'd0);
        check("midrst_rd_data", {24'd0, rd_data}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        local_rd(7'h20, v);
        check("midrst_reg20", {24'd0, v}, 32'h00);
        local_rd(7'h7F, v);
        check("midrst_reg7f", {24'd0, v}, 32'h00);
        local_rd(7'h0F, v);
        check("midrst_reg0f", {24'd0, v}, 32'h68);
        // cs_n still low: bits must be ignored until a fresh select
        spi_byte(2, 8'h20, 8, 1'b0, 7'h00, 8'h00);
        spi_byte(3, 8'hEE, 8, 1'b0, 7'h00, 8'h00);
        check("midrst_ignored_wr", wq_addr.size(), 32'd0);
        check("midrst_ignored_oe", {31'd0, oe_any[3]}, 32'd0);
        repeat (Half) @(negedge clk);
        spi_bus.cs_n = 1'b1;
        repeat (Half) @(negedge clk);
        local_rd(7'h20, v);
        check("midrst_reg20_kept", {24'd0, v}, 32'h00);
        set_tx(8'h20, 8'hEE, 8'h00, 8'h00);
        spi_xfer(2);
        local_rd(7'h20, v);
        check("postrst_write", {24'd0, v}, 32'hEE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
